// File: rtl/data_search8.sv
// data_search8 -- binary search driving an external magnitude comparator.
//
// Each probe presents the midpoint of the live [lo, hi] window on oProbe and
// narrows the window from the comparator's one-hot answer, until it is told
// "equal", the window empties, or the answer is malformed.
//
// Optional feature: define DATA_SEARCH_TIMEOUT_EN to abort a search with
// oError after TIMEOUT consecutive PROBE cycles without iCmpValid. Without it
// the search waits for a response indefinitely.
//
// Ports:
//   iClk, iRst_n      clock, asynchronous active-low reset
//   iStart            start a search (only looked at in IDLE)
//   oProbe            candidate value (comparator operand a)
//   oProbeValid       oProbe is valid and waiting for a response
//   iCmpValid, iCmp   response strobe and one-hot result
//                     (100 probe>target, 010 probe<target, 001 equal)
//   oBusy             search in progress
//   oDone             one-cycle end-of-search pulse
//   oFound, oError    outcome of the last search (meaningful with oDone)
//   oResult           last located value
module data_search8 #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  output logic [WIDTH-1:0] oProbe,
  output logic             oProbeValid,
  input  logic             iCmpValid,
  input  logic [2:0]       iCmp,
  output logic             oBusy,
  output logic             oDone,
  output logic             oFound,
  output logic [WIDTH-1:0] oResult,
  output logic             oError
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q, found_d, error_q, error_d;

  // Midpoint taken from a WIDTH+1 bit sum so lo+hi never wraps.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mid;
  assign sum = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid = sum[WIDTH:1];

  logic tmo;

`ifdef DATA_SEARCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;

  // Counts consecutive response-less PROBE cycles; cleared outside PROBE.
  always_comb begin
    tcnt_d = '0;
    if (state_q == PROBE && !iCmpValid) tcnt_d = tcnt_q + 1'b1;
  end

  assign tmo = (state_q == PROBE) && !iCmpValid && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) tcnt_q <= '0;
    else         tcnt_q <= tcnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    found_d  = found_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          lo_d    = '0;
          hi_d    = MAXV;
          state_d = PROBE;
        end
      end
      PROBE: begin
        if (iCmpValid) begin
          case (iCmp)
            3'b001: begin
              result_d = mid;
              found_d  = 1'b1;
              error_d  = 1'b0;
              state_d  = DONE;
            end
            3'b100: begin
              // Nothing below probe 0, or the window closes: not found.
              if (mid == '0 || lo_q > (mid - ONE)) begin
                found_d = 1'b0;
                error_d = 1'b0;
                state_d = DONE;
              end else begin
                hi_d = mid - ONE;
              end
            end
            3'b010: begin
              if (mid == MAXV || (mid + ONE) > hi_q) begin
                found_d = 1'b0;
                error_d = 1'b0;
                state_d = DONE;
              end else begin
                lo_d = mid + ONE;
              end
            end
            default: begin
              found_d = 1'b0;
              error_d = 1'b1;
              state_d = DONE;
            end
          endcase
        end else if (tmo) begin
          found_d = 1'b0;
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      found_q  <= found_d;
      error_q  <= error_d;
    end
  end

  assign oBusy       = (state_q == PROBE);
  assign oProbeValid = (state_q == PROBE);
  assign oProbe      = (state_q == PROBE) ? mid : '0;
  assign oDone       = (state_q == DONE);
  assign oFound      = found_q;
  assign oError      = error_q;
  assign oResult     = result_q;

endmodule
